// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone initiator, its responders and benches.
package wbm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } wbm_state_e;

  localparam int unsigned WBM_ADDRWIDTH      = 32'd9;
  localparam int unsigned WBM_DATAWIDTH      = 32'd32;
  localparam int unsigned WBM_TIMEOUT_CYCLES = 32'd64;

  // FPGA register map
  localparam logic [8:0] ADR_ID       = 9'h000;
  localparam logic [8:0] ADR_REV      = 9'h001;
  localparam logic [8:0] ADR_GPIO_IN  = 9'h002;
  localparam logic [8:0] ADR_GPIO_OUT = 9'h003;
  localparam logic [8:0] ADR_GPIO_OE  = 9'h004;
  localparam logic [8:0] ADR_FIFO1_0  = 9'h040;
  localparam logic [8:0] ADR_FIFO1_1  = 9'h041;
  localparam logic [8:0] ADR_FIFO2_0  = 9'h080;
  localparam logic [8:0] ADR_FIFO2_1  = 9'h081;

endpackage

// File: rtl/wbm_timeout_cnt.sv
// REQ-phase watchdog for wb_master_seq; only instantiated when WBM_TIMEOUT_EN is defined.
module wbm_timeout_cnt
  import wbm_pkg::*;
#(
  parameter int unsigned LIMIT = WBM_TIMEOUT_CYCLES
) (
  input  logic WBs_CLK_i,
  input  logic WBs_RST_i,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (LIMIT > 32'd1) ? $clog2(LIMIT) : 32'd1;
  localparam logic [CW-1:0] LAST_P = CW'(LIMIT - 32'd1);

  logic [CW-1:0] count_r;

  assign expire = (count_r == LAST_P);

  // Count REQ cycles without ACK; saturates at the last value until cleared.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable && !expire) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/wb_master_seq.sv
// Single-command Wishbone classic initiator with valid/ready command and response channels.
// Optional ACK watchdog enabled by defining WBM_TIMEOUT_EN.
module wb_master_seq
  import wbm_pkg::*;
#(
  parameter int unsigned ADDRWIDTH      = WBM_ADDRWIDTH,
  parameter int unsigned DATAWIDTH      = WBM_DATAWIDTH,
  parameter int unsigned TIMEOUT_CYCLES = WBM_TIMEOUT_CYCLES
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [3:0]           cmd_be_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic [ADDRWIDTH-1:0] WBs_ADR_o,
  output logic                 WBs_CYC_o,
  output logic                 WBs_STB_o,
  output logic                 WBs_WE_o,
  output logic                 WBs_RD_o,
  output logic [3:0]           WBs_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  input  logic                 WBs_ACK_i
);

  localparam logic [DATAWIDTH-1:0] ZERO_DAT = {DATAWIDTH{1'b0}};

  wbm_state_e           state_r;
  logic                 cmd_ready_r;
  logic                 cyc_r;
  logic                 stb_r;
  logic                 we_r;
  logic                 rd_r;
  logic [ADDRWIDTH-1:0] adr_r;
  logic [3:0]           be_r;
  logic [DATAWIDTH-1:0] dat_r;
  logic                 rsp_valid_r;
  logic [DATAWIDTH-1:0] rsp_dat_r;
  logic                 rsp_err_r;
  logic                 accept_s;
  logic                 expire_s;

  assign accept_s = (state_r == IDLE) && cmd_valid_i && cmd_ready_r;

`ifdef WBM_TIMEOUT_EN
  logic tmo_en_s;

  assign tmo_en_s = (state_r == REQ) && !WBs_ACK_i;

  wbm_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .WBs_CLK_i (WBs_CLK_i),
    .WBs_RST_i (WBs_RST_i),
    .clear     (accept_s),
    .enable    (tmo_en_s),
    .expire    (expire_s)
  );
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign expire_s = 1'b0;
`endif

  // Command/bus/response sequencer; every output is a register of this block.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b1;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      rd_r        <= 1'b0;
      adr_r       <= {ADDRWIDTH{1'b0}};
      be_r        <= 4'h0;
      dat_r       <= ZERO_DAT;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= ZERO_DAT;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            adr_r       <= cmd_adr_i;
            be_r        <= cmd_be_i;
            dat_r       <= cmd_dat_i;
            we_r        <= cmd_we_i;
            rd_r        <= ~cmd_we_i;
            cyc_r       <= 1'b1;
            stb_r       <= 1'b1;
            cmd_ready_r <= 1'b0;
            state_r     <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          // ACK takes priority over a watchdog expiring in the same cycle.
          if (WBs_ACK_i) begin
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            rd_r        <= 1'b0;
            rsp_dat_r   <= we_r ? ZERO_DAT : WBs_DAT_i;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= RSP;
          end else if (expire_s) begin
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            rd_r        <= 1'b0;
            rsp_dat_r   <= ZERO_DAT;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= RSP;
          end else begin
            state_r <= REQ;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= RSP;
          end
        end
        default: begin
          state_r     <= IDLE;
          cmd_ready_r <= 1'b1;
          cyc_r       <= 1'b0;
          stb_r       <= 1'b0;
          we_r        <= 1'b0;
          rd_r        <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o    = cmd_ready_r;
  assign rsp_valid_o    = rsp_valid_r;
  assign rsp_dat_o      = rsp_dat_r;
  assign rsp_err_o      = rsp_err_r;
  assign WBs_ADR_o      = adr_r;
  assign WBs_CYC_o      = cyc_r;
  assign WBs_STB_o      = stb_r;
  assign WBs_WE_o       = we_r;
  assign WBs_RD_o       = rd_r;
  assign WBs_BYTE_STB_o = be_r;
  assign WBs_DAT_o      = dat_r;

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed scoreboard bench for wb_master_seq against a small register-block responder.
module tb_wb_master_seq;
  import wbm_pkg::*;

`ifdef WBM_TIMEOUT_EN
  localparam int unsigned TMO = 16;
  localparam int HANG_CYCLES = 5;
`else
  localparam int unsigned TMO = 64;
  localparam int HANG_CYCLES = 1000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [8:0]  cmd_adr_i;
  logic [3:0]  cmd_be_i;
  logic [31:0] cmd_dat_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic [8:0]  WBs_ADR_o;
  logic        WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o;
  logic [3:0]  WBs_BYTE_STB_o;
  logic [31:0] WBs_DAT_o, WBs_DAT_i;
  logic        WBs_ACK_i;

  int n_cmp = 0;
  int n_mis = 0;
  int n_issued = 0;
  int n_rsp = 0;
  logic [32:0] exp_q[$];

  wb_master_seq #(.ADDRWIDTH(9), .DATAWIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_be_i(cmd_be_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .WBs_ADR_o(WBs_ADR_o), .WBs_CYC_o(WBs_CYC_o),
    .WBs_STB_o(WBs_STB_o), .WBs_WE_o(WBs_WE_o), .WBs_RD_o(WBs_RD_o),
    .WBs_BYTE_STB_o(WBs_BYTE_STB_o), .WBs_DAT_o(WBs_DAT_o), .WBs_DAT_i(WBs_DAT_i),
    .WBs_ACK_i(WBs_ACK_i)
  );

  always #5 clk = ~clk;

  // Responder: registered ACK after ack_low REQ cycles, never re-acks a held strobe.
  int          ack_low = 1;
  bit          never_ack = 1'b0;
  logic        resp_ack;
  logic        stray_ack = 1'b0;
  logic [31:0] resp_dat;
  logic [31:0] gpio_out;
  int          wcnt;

  assign WBs_ACK_i = resp_ack | stray_ack;
  assign WBs_DAT_i = resp_dat;

  function automatic logic [31:0] rd_model(input logic [8:0] adr);
    case (adr)
      ADR_ID:       return 32'hF1F07E57;
      ADR_REV:      return 32'h00000100;
      ADR_GPIO_IN:  return 32'h0000005A;
      ADR_GPIO_OUT: return gpio_out;
      default:      return 32'h00000000;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_ack <= 1'b0;
      wcnt     <= 0;
      resp_dat <= 32'h0;
      gpio_out <= 32'h0;
    end else begin
      resp_ack <= 1'b0;
      if (WBs_CYC_o && WBs_STB_o && !resp_ack && !never_ack) begin
        if (wcnt >= ack_low - 1) begin
          resp_ack <= 1'b1;
          wcnt     <= 0;
          if (WBs_WE_o) begin
            resp_dat <= 32'hBAD0BAD0;
            if (WBs_ADR_o == ADR_GPIO_OUT)
              for (int b = 0; b < 4; b++)
                if (WBs_BYTE_STB_o[b]) gpio_out[8*b +: 8] <= WBs_DAT_o[8*b +: 8];
          end else begin
            resp_dat <= rd_model(WBs_ADR_o);
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  // Count strobe launches and response handshakes.
  int   stb_rises = 0;
  int   rsp_hs = 0;
  logic stb_q = 1'b0;
  always @(posedge clk) begin
    stb_q <= WBs_STB_o;
    if (WBs_STB_o && !stb_q) stb_rises <= stb_rises + 1;
    if (rsp_valid_o && rsp_ready_i) rsp_hs <= rsp_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic we, input logic [8:0] adr, input logic [3:0] be,
                        input logic [31:0] dat, input logic [31:0] exp_dat,
                        input logic exp_err, input int exp_req, input int hold);
    int          lat;
    int          cyc_cnt;
    logic        stable;
    logic [32:0] exp;
    rsp_ready_i = (hold == 0);
    check("cmd_ready idle", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_be_i = be; cmd_dat_i = dat;
    exp_q.push_back({exp_err, exp_dat});
    n_issued++;
    @(negedge clk);
    cmd_valid_i = 1'b0; cmd_we_i = ~we; cmd_adr_i = ~adr; cmd_be_i = ~be; cmd_dat_i = ~dat;
    check("bus launch", {WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o, cmd_ready_o},
          {1'b1, 1'b1, we, ~we, 1'b0});
    check("bus adr/be", {WBs_ADR_o, WBs_BYTE_STB_o}, {adr, be});
    check("bus dat", WBs_DAT_o, dat);
    lat = 0; cyc_cnt = 0; stable = 1'b1;
    while (!rsp_valid_o && lat < 2000) begin
      if (WBs_CYC_o) cyc_cnt++;
      if (WBs_ADR_o !== adr || WBs_DAT_o !== dat || WBs_BYTE_STB_o !== be ||
          WBs_STB_o !== WBs_CYC_o || WBs_WE_o !== (WBs_CYC_o & we) ||
          WBs_RD_o !== (WBs_CYC_o & ~we) || cmd_ready_o !== 1'b0) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("req stable", stable, 1'b1);
    check("rsp latency", lat, exp_req);
    check("cyc cycles", cyc_cnt, exp_req);
    check("bus idle after ack", {WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o}, 4'h0);
    for (int i = 0; i < hold; i++) begin
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== exp_dat || rsp_err_o !== exp_err ||
          cmd_ready_o !== 1'b0 || WBs_CYC_o !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) check("backpressure hold", stable, 1'b1);
    rsp_ready_i = 1'b1;
    exp = exp_q.pop_front();
    check("rsp valid", rsp_valid_o, 1'b1);
    check("rsp data", rsp_dat_o, exp[31:0]);
    check("rsp err", rsp_err_o, exp[32]);
    @(negedge clk);
    n_rsp++;
    check("post handshake", {rsp_valid_o, cmd_ready_o, WBs_CYC_o}, 3'b010);
  endtask

  initial begin
    int hang;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = 9'h0;
    cmd_be_i = 4'h0; cmd_dat_i = 32'h0; rsp_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("reset bus ctl", {WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o, WBs_BYTE_STB_o}, 8'h00);
    check("reset adr/dat", {WBs_ADR_o, WBs_DAT_o}, 41'h0);
    check("reset rsp", {rsp_valid_o, rsp_err_o, rsp_dat_o}, 34'h0);
    check("reset cmd_ready", cmd_ready_o, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // zero-wait read of the ID register
    do_cmd(1'b0, ADR_ID, 4'hF, 32'h0, 32'hF1F07E57, 1'b0, 2, 0);

    // write then read back with byte strobes
    do_cmd(1'b1, ADR_GPIO_OUT, 4'h1, 32'h000000A5, 32'h0, 1'b0, 2, 0);
    check("gpio_out byte0", gpio_out[7:0], 8'hA5);
    check("bus retained idle", {WBs_ADR_o, WBs_BYTE_STB_o, WBs_DAT_o}, {ADR_GPIO_OUT, 4'h1, 32'h000000A5});
    do_cmd(1'b0, ADR_GPIO_OUT, 4'hF, 32'h0, 32'h000000A5, 1'b0, 2, 0);
    do_cmd(1'b1, ADR_GPIO_OUT, 4'h6, 32'h12345678, 32'h0, 1'b0, 2, 0);
    do_cmd(1'b0, ADR_GPIO_OUT, 4'hF, 32'h0, 32'h003456A5, 1'b0, 2, 0);

    // response backpressure
    do_cmd(1'b0, ADR_REV, 4'hF, 32'h0, 32'h00000100, 1'b0, 2, 5);

    // stray ACK while idle
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray ack ignored", {rsp_valid_o, cmd_ready_o, WBs_CYC_o}, 3'b010);

    // wait states: ACK low for 7 REQ cycles
    ack_low = 7;
    do_cmd(1'b0, ADR_GPIO_IN, 4'hF, 32'h0, 32'h0000005A, 1'b0, 8, 0);
    ack_low = 1;

`ifdef WBM_TIMEOUT_EN
    never_ack = 1'b1;
    do_cmd(1'b0, ADR_ID, 4'hF, 32'h0, 32'h0, 1'b1, 16, 0);
    never_ack = 1'b0;
`endif

    // hung cycle, then reset in the middle of REQ
    never_ack = 1'b1;
    check("cmd_ready before hang", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = ADR_ID; cmd_be_i = 4'hF;
    n_issued++;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    hang = 0;
    for (int i = 0; i < HANG_CYCLES; i++) begin
      if (WBs_CYC_o && !rsp_valid_o) hang++;
      @(negedge clk);
    end
    check("cyc held without ack", hang, HANG_CYCLES);
    #2 rst = 1'b1;
    #1 check("async reset drop", {WBs_CYC_o, WBs_STB_o, WBs_RD_o, rsp_valid_o, cmd_ready_o}, 5'b00001);
    never_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("no pending expectation", exp_q.size(), 0);
    do_cmd(1'b0, ADR_ID, 4'hF, 32'h0, 32'hF1F07E57, 1'b0, 2, 0);

    check("strobe launches", stb_rises, n_issued);
    check("response handshakes", rsp_hs, n_rsp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_master_seq.md
Name: wb_master_seq

Overview:
- Wishbone initiator: the requesting end of the WBs_* bus that the FPGA register/FIFO blocks respond to.
- Accepts single read/write commands over a valid/ready handshake and runs one Wishbone classic cycle per command.
- Waits for the responder's ACK, then returns the read data and a status through a valid/ready response channel.
- Used by on-fabric engines (DMA, self-test, sensor pollers) that need to reach the register map without the AHB bridge.

Parameters:
ADDRWIDTH, 9, Wishbone address width
DATAWIDTH, 32, Wishbone data width
TIMEOUT_CYCLES, 64, cycles without ACK before abort (only used with WBM_TIMEOUT_EN)

Ports:
WBs_CLK_i  in  1  clock
WBs_RST_i  in  1  asynchronous active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when high with cmd_valid_i
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  ADDRWIDTH  target address
cmd_be_i  in  4  byte strobes
cmd_dat_i  in  DATAWIDTH  write data
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed
rsp_dat_o  out  DATAWIDTH  read data (0 for writes)
rsp_err_o  out  1  cycle aborted by timeout
WBs_ADR_o  out  ADDRWIDTH  bus address
WBs_CYC_o  out  1  cycle
WBs_STB_o  out  1  strobe
WBs_WE_o  out  1  write enable
WBs_RD_o  out  1  read enable (STB & ~WE)
WBs_BYTE_STB_o  out  4  byte select
WBs_DAT_o  out  DATAWIDTH  write data
WBs_DAT_i  in  DATAWIDTH  read data from responder
WBs_ACK_i  in  1  acknowledge from responder

Behaviour:
- Clock and reset: WBs_CLK_i clocks all state. WBs_RST_i is asynchronous, active-high.
- Reset values:
  - state=IDLE; all WBs_* outputs 0; cmd_ready_o=1.
  - rsp_valid_o=0; rsp_dat_o=0; rsp_err_o=0; timeout counter 0.
- All bus outputs are registered. No combinational path from any input to WBs_* outputs.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i&cmd_ready_o at edge T0: latch adr/we/be/dat onto WBs_* outputs, set CYC=STB=1, WE=cmd_we_i, RD=~cmd_we_i, go to REQ.
- REQ:
  - cmd_ready_o=0; bus outputs held stable.
  - At an edge with WBs_ACK_i=1:
    - CYC/STB/WE/RD go to 0.
    - rsp_dat_o <= (WE ? 0 : WBs_DAT_i); rsp_err_o <= 0; rsp_valid_o <= 1.
    - Go to RSP.
  - A zero-wait responder (ACK registered one cycle after CYC&STB) gives ACK high after T1 and rsp_valid_o high after T2: 2 cycles accept→response.
- RSP:
  - rsp_valid_o=1 and rsp_dat_o/rsp_err_o held until rsp_valid_o&rsp_ready_i.
  - On that handshake, clear rsp_valid_o and go to IDLE. cmd_ready_o becomes 1 in the following cycle; no command/response overlap.
  - Minimum command-to-command spacing: 3 cycles.
- CYC/STB must be low on the cycle after ACK is sampled, so responders that compute ACK_nxt = CYC&STB&~ACK never see a second strobe.
- WBs_ACK_i while not in REQ is ignored.
- ADR/DAT/BYTE_STB retain their last values when idle; only CYC/STB/WE/RD are cleared.
- Reset mid-cycle: all outputs drop immediately (async). Any outstanding command and response are discarded and not replayed.

Optional Feature:
- Macro: WBM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ACK.
  - When it reaches TIMEOUT_CYCLES-1 with no ACK, the next edge drops CYC/STB/WE/RD, sets rsp_err_o=1, rsp_dat_o=0, rsp_valid_o=1, and enters RSP.
  - ACK on that same final cycle wins: normal response, err=0.
- Undefined:
  - No counter is built; REQ waits indefinitely.
  - rsp_err_o is tied 0.

Decomposition:
- Package wbm_pkg holds:
  - state enum {IDLE, REQ, RSP};
  - default ADDRWIDTH/DATAWIDTH/TIMEOUT_CYCLES;
  - shared register-map address constants (ID 9'h0, REV 9'h1, GPIO_IN 9'h2, GPIO_OUT 9'h3, GPIO_OE 9'h4, FIFO1 9'h40/9'h41, FIFO2 9'h80/9'h81), reused by benches and responders.
- One sub-module: wbm_timeout_cnt (clear/enable/expire), instantiated only under WBM_TIMEOUT_EN.

Test Plan:
1. Read, zero-wait: read 9'h0 with rsp_ready_i=1 against the FPGA register block → rsp_dat_o=32'hF1F07E57, err=0; rsp_valid_o exactly 2 cycles after accept; CYC high exactly 2 cycles.
2. Write then read-back: write 9'h3, be=4'h1, dat=32'hA5 → register output 8'hA5. Read 9'h3 → rsp_dat_o=32'h000000A5. The write response has rsp_dat_o=0.
3. Response backpressure: rsp_ready_i low 5 cycles after a read of 9'h1 → rsp_valid_o and rsp_dat_o=32'h100 stable throughout; cmd_ready_o=0; no new CYC. Accepted on cycle 6; cmd_ready_o=1 the following cycle.
4. Wait states: responder stalls ACK 7 cycles → bus outputs stable for 8 REQ cycles; one response only; no second STB after ACK.
5. Timeout (WBM_TIMEOUT_EN, TIMEOUT_CYCLES=16): ACK never asserted → CYC drops after 16 REQ cycles; rsp_err_o=1, rsp_dat_o=0. With the macro undefined, CYC stays high 1000 cycles.
6. Reset mid-cycle: assert WBs_RST_i during REQ → CYC/STB/rsp_valid_o are 0 before the next edge. After release: cmd_ready_o=1, and a fresh read of 9'h0 completes normally.
